neuron_mac: RTL

Sequential multiply-accumulate neuron for the fully-connected layers of the on-chip classifier. It consumes one activation per cycle from the previous layer and weights each one from an internal weight store. It then adds a bias, rescales, saturates and applies the activation function, emitting one result per input vector. Ten instances, packed side by side, form the output layer that feeds the argmax stage; their `o_valid` lines, aligned, drive its `i_valid`.

---
 rtl/nn_pkg.sv | 29 ++
 rtl/weight_mem.sv | 30 +++
 rtl/neuron_mac.sv | 114 +++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// nn_pkg : shared types, fixed-point defaults and saturation helper
// Rev 1.0
// ============================================================================
package nn_pkg;

    typedef enum logic {
        ACT_RELU  = 1'b0,
        ACT_IDENT = 1'b1
    } act_e;

    localparam int c_DATA_WIDTH = 16;
    localparam int c_FRAC_BITS  = 8;

    // Clamp a wide signed value into the signed range of `width` bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned       width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (v > max_v) return max_v;
        if (v < min_v) return min_v;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/weight_mem.sv
`default_nettype none
// ============================================================================
// weight_mem : single-write, single synchronous-read weight store (no reset)
// Rev 1.0
// ============================================================================
module weight_mem #(
    parameter int DEPTH  = 784,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// neuron_mac : sequential MAC neuron -- weight, accumulate, bias, rescale,
//              saturate and activate; one result per input vector
// Rev 1.0
// ============================================================================
module neuron_mac
    import nn_pkg::*;
#(
    parameter int   NUM_WEIGHT = 784,
    parameter int   DATA_WIDTH = c_DATA_WIDTH,
    parameter int   FRAC_BITS  = c_FRAC_BITS,
    parameter act_e ACT_TYPE   = ACT_RELU
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [DATA_WIDTH-1:0]         i_x,
    input  logic                          i_x_valid,
    input  logic                          i_wt_wen,
    input  logic [$clog2(NUM_WEIGHT)-1:0] i_wt_addr,
    input  logic [DATA_WIDTH-1:0]         i_wt_data,
    input  logic                          i_bias_wen,
    input  logic [DATA_WIDTH-1:0]         i_bias_data,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_valid,
    output logic                          o_busy
);

    localparam int c_AW   = $clog2(NUM_WEIGHT);
    localparam int c_PW   = 2 * DATA_WIDTH;
    localparam int c_ACCW = c_PW + c_AW;
    localparam int c_SW   = c_ACCW + 1;

    logic [c_AW-1:0]              r_cnt;
    logic                         w_cnt_last;
    logic                         w_wt_we;
    logic signed [DATA_WIDTH-1:0] w_wt;
    logic signed [DATA_WIDTH-1:0] r_bias;

    logic                         r_s1_valid, r_s1_first, r_s1_last;
    logic signed [DATA_WIDTH-1:0] r_s1_x;
    logic                         r_s2_valid, r_s2_first, r_s2_last;
    logic signed [c_PW-1:0]       r_s2_prod;
    logic                         r_s3_last;
    logic signed [c_ACCW-1:0]     r_acc;

    logic signed [c_SW-1:0]       w_sum;
    logic signed [c_SW-1:0]       w_scaled;
    logic signed [DATA_WIDTH-1:0] w_sat;
    logic signed [DATA_WIDTH-1:0] w_act;
    logic [DATA_WIDTH-1:0]        r_data;
    logic                         r_valid;

    assign w_cnt_last = (r_cnt == c_AW'(NUM_WEIGHT - 1));
    assign o_busy     = (r_cnt != '0) | r_s1_valid | r_s2_valid | r_s3_last;
    assign w_wt_we    = i_wt_wen & ~o_busy;

    weight_mem #(
        .DEPTH  (NUM_WEIGHT),
        .WIDTH  (DATA_WIDTH),
        .ADDR_W (c_AW)
    ) u_weight_mem (
        .clk     (CLK),
        .i_we    (w_wt_we),
        .i_waddr (i_wt_addr),
        .i_wdata (i_wt_data),
        .i_raddr (r_cnt),
        .o_rdata (w_wt)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_last  <= 1'b0;
            r_acc      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (i_x_valid) r_cnt <= w_cnt_last ? '0 : r_cnt + c_AW'(1);
            r_s1_valid <= i_x_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_last  <= r_s2_valid & r_s2_last;
            // A "first" product restarts the sum, so vectors can abut.
            if (r_s2_valid)
                r_acc <= r_s2_first ? c_ACCW'(r_s2_prod) : r_acc + c_ACCW'(r_s2_prod);
            r_valid <= r_s3_last;
            if (r_s3_last) r_data <= w_act;
        end
    end

    always_ff @(posedge CLK) begin
        r_s1_x     <= i_x;
        r_s1_first <= (r_cnt == '0);
        r_s1_last  <= w_cnt_last;
        r_s2_prod  <= c_PW'(r_s1_x) * c_PW'(w_wt);
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        if (i_bias_wen && !o_busy) r_bias <= i_bias_data;
    end

    always_comb begin
        w_sum    = c_SW'(r_acc) + (c_SW'(r_bias) <<< FRAC_BITS);
        w_scaled = w_sum >>> FRAC_BITS;
        w_sat    = DATA_WIDTH'(sat_signed(64'(w_scaled), DATA_WIDTH));
        w_act    = (ACT_TYPE == ACT_RELU && w_sat[DATA_WIDTH-1]) ? '0 : w_sat;
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
`default_nettype wire
